puf_eval_ctrl: RTL and testbench

Parametrised evaluation controller for an arbiter-style PUF core such as the feed-forward arbiter PUF. It accepts a challenge over a valid/ready handshake and holds that challenge on the core. It then launches and samples the core NEVAL times and majority-votes each response bit. The result is returned over a valid/ready handshake together with a per-bit instability mask. It sits between the challenge source (host or LFSR) and the PUF core, replacing the free-running direct wrapper.

---
 rtl/puf_pkg.sv | 26 ++
 rtl/puf_vote_bit.sv | 36 +++
 rtl/puf_eval_ctrl.sv | 112 +++++++++++
 tb/tb_puf_eval_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF evaluation controller.
// State encoding, ceiling-log2 helper and default datapath widths.
package puf_pkg;

    localparam int unsigned DEF_CW = 32;
    localparam int unsigned DEF_RW = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        RUN    = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Ceiling log2, never below 1 so it is always usable as a vector width.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/puf_vote_bit.sv
// Per-bit vote accumulator: counts ones across evaluations and derives the
// majority and unanimity flags from the count including the current sample.
module puf_vote_bit
    import puf_pkg::*;
#(
    parameter int unsigned NEVAL = 5
) (
    input  logic clk,
    input  logic clear,
    input  logic start,
    input  logic sample,
    input  logic bit_in,
    output logic maj,
    output logic unstable
);

    localparam int unsigned VW = clog2(NEVAL + 1);

    logic [VW-1:0] vote;
    logic [VW-1:0] vote_nxt;

    assign vote_nxt = vote + VW'(bit_in);

    always_ff @(posedge clk) begin
        if (clear || start) begin
            vote <= '0;
        end else if (sample) begin
            vote <= vote_nxt;
        end
    end

    // Flags look at vote_nxt so the final sample is included on the DONE entry edge.
    assign maj      = (vote_nxt > VW'(NEVAL / 2));
    assign unstable = (vote_nxt != '0) && (vote_nxt != VW'(NEVAL));

endmodule

// File: rtl/puf_eval_ctrl.sv
// Evaluation controller for an arbiter PUF: holds a challenge, runs NEVAL
// clear/race/sample cycles, and returns a majority-voted response with an instability mask.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned CW     = DEF_CW,
    parameter int unsigned RW     = DEF_RW,
    parameter int unsigned NEVAL  = 5,
    parameter int unsigned SETTLE = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          chal_valid,
    output logic          chal_ready,
    input  logic [CW-1:0] chal,
    output logic [CW-1:0] puf_chal,
    output logic          puf_clr,
    input  logic [RW-1:0] puf_resp,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [RW-1:0] resp,
    output logic [RW-1:0] resp_unstable,
    output logic          busy
);

    if ((NEVAL % 2) == 0 || NEVAL < 1 || NEVAL > 255 || SETTLE < 1) begin : g_bad_params
        $error("puf_eval_ctrl: NEVAL must be odd in 1..255 and SETTLE >= 1");
    end

    localparam int unsigned EW = clog2(NEVAL + 1);
    localparam int unsigned SW = clog2(SETTLE + 1);

    state_t        state;
    state_t        state_nxt;
    logic [EW-1:0] eval_cnt;
    logic [SW-1:0] settle_cnt;
    logic [RW-1:0] maj_v;
    logic [RW-1:0] unst_v;
    logic          accept;
    logic          last_eval;

    assign accept    = (state == IDLE) && chal_valid;
    assign last_eval = (eval_cnt == EW'(NEVAL - 1));

    for (genvar i = 0; i < RW; i++) begin : g_vote
        puf_vote_bit #(.NEVAL(NEVAL)) u_vote (
            .clk      (clk),
            .clear    (clear),
            .start    (accept),
            .sample   (state == SAMPLE),
            .bit_in   (puf_resp[i]),
            .maj      (maj_v[i]),
            .unstable (unst_v[i])
        );
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state         <= IDLE;
            puf_chal      <= '0;
            resp          <= '0;
            resp_unstable <= '0;
            eval_cnt      <= '0;
            settle_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                puf_chal <= chal;
                eval_cnt <= '0;
            end
            if (state == ARM) settle_cnt <= '0;
            if (state == RUN) settle_cnt <= settle_cnt + 1'b1;
            if (state == SAMPLE) begin
                eval_cnt <= eval_cnt + 1'b1;
                if (last_eval) begin
                    resp          <= maj_v;
                    resp_unstable <= unst_v;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        chal_ready = 1'b0;
        puf_clr    = 1'b1;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                chal_ready = 1'b1;
                busy       = 1'b0;
                if (chal_valid) state_nxt = ARM;
            end
            ARM: state_nxt = RUN;
            RUN: begin
                puf_clr = 1'b0;
                if (settle_cnt == SW'(SETTLE - 1)) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                puf_clr   = 1'b0;
                state_nxt = last_eval ? DONE : ARM;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: default instance plus a NEVAL=1/SETTLE=1 instance,
// each driven by a behavioural PUF that returns noise while cleared.
module tb_puf_eval_ctrl;

    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Default instance
    logic        c0_valid = 1'b0, c0_ready, p0_clr, r0_valid, r0_ready = 1'b0, b0;
    logic [31:0] c0_chal = '0, p0_chal, p0_resp = '0, r0_resp, r0_unst;

    puf_eval_ctrl u_dut0 (
        .clk(clk), .clear(clear), .chal_valid(c0_valid), .chal_ready(c0_ready),
        .chal(c0_chal), .puf_chal(p0_chal), .puf_clr(p0_clr), .puf_resp(p0_resp),
        .resp_valid(r0_valid), .resp_ready(r0_ready), .resp(r0_resp),
        .resp_unstable(r0_unst), .busy(b0)
    );

    // Single-sample instance
    logic        c1_valid = 1'b0, c1_ready, p1_clr, r1_valid, r1_ready = 1'b0, b1;
    logic [31:0] c1_chal = '0, p1_chal, p1_resp = '0, r1_resp, r1_unst;

    puf_eval_ctrl #(.CW(32), .RW(32), .NEVAL(1), .SETTLE(1)) u_dut1 (
        .clk(clk), .clear(clear), .chal_valid(c1_valid), .chal_ready(c1_ready),
        .chal(c1_chal), .puf_chal(p1_chal), .puf_clr(p1_clr), .puf_resp(p1_resp),
        .resp_valid(r1_valid), .resp_ready(r1_ready), .resp(r1_resp),
        .resp_unstable(r1_unst), .busy(b1)
    );

    // PUF model 0: evaluation k (counted by race-end events since st0) returns base ^ flip[k].
    logic [31:0] m0_base = '0;
    logic [31:0] m0_flip [8];
    int ev0 = 0, st0 = 0, idx0;
    logic prev0 = 1'b1;
    always @(negedge clk) begin
        if (prev0 === 1'b0 && p0_clr === 1'b1) ev0 = ev0 + 1;
        prev0 = p0_clr;
        idx0  = ev0 - st0;
        if (p0_clr !== 1'b0) p0_resp = $urandom;
        else p0_resp = m0_base ^ ((idx0 >= 0 && idx0 < 8) ? m0_flip[idx0] : 32'h0);
    end

    logic [31:0] m1_base = '0;
    always @(negedge clk) p1_resp = (p1_clr !== 1'b0) ? $urandom : m1_base;

    // Reference: count ones per bit over the n evaluation values, majority and unanimity.
    function automatic void ref_vote(input logic [31:0] base, input int n,
                                     output logic [31:0] r, output logic [31:0] u);
        int ones;
        logic [31:0] v;
        r = '0; u = '0;
        for (int b = 0; b < 32; b++) begin
            ones = 0;
            for (int k = 0; k < n; k++) begin
                v = base ^ m0_flip[k];
                ones += int'(v[b]);
            end
            r[b] = (2 * ones > n);
            u[b] = (ones != 0) && (ones != n);
        end
    endfunction

    task automatic clear_flips();
        for (int k = 0; k < 8; k++) m0_flip[k] = '0;
    endtask

    task automatic run_txn(input logic [31:0] c, input int hold, input bit offer);
        logic [31:0] er, eu;
        int acc;
        ref_vote(m0_base, 5, er, eu);
        @(negedge clk);
        c0_chal = c; c0_valid = 1'b1; r0_ready = 1'b0;
        check("rdy_idle", 32'(c0_ready), 32'd1);
        acc = cyc; st0 = ev0;
        @(negedge clk);
        c0_valid = 1'b0; c0_chal = $urandom;
        for (int n = 0; n < 200 && r0_valid !== 1'b1; n++) @(negedge clk);
        check("valid_seen", 32'(r0_valid), 32'd1);
        check("latency", 32'(cyc - acc), 32'd31);
        check("resp", r0_resp, er);
        check("unstable", r0_unst, eu);
        check("puf_chal", p0_chal, c);
        for (int i = 0; i < hold; i++) begin
            if (offer) begin c0_valid = 1'b1; c0_chal = ~c; end
            @(negedge clk);
            check("stall_valid", 32'(r0_valid), 32'd1);
            check("stall_resp", r0_resp, er);
            check("stall_unst", r0_unst, eu);
            check("stall_chal", p0_chal, c);
            check("stall_rdy", 32'(c0_ready), 32'd0);
        end
        r0_ready = 1'b1; c0_valid = 1'b0;
        @(negedge clk);
        r0_ready = 1'b0;
        check("ack_valid", 32'(r0_valid), 32'd0);
        check("ack_rdy", 32'(c0_ready), 32'd1);
        check("held_resp", r0_resp, er);
        check("held_chal", p0_chal, c);
    endtask

    initial begin
        logic [31:0] er, eu, ca, cb;
        int acc, d;
        clear_flips();
        repeat (3) @(negedge clk);
        check("rst_chal", p0_chal, 32'h0);
        check("rst_clr", 32'(p0_clr), 32'd1);
        check("rst_resp", r0_resp, 32'h0);
        check("rst_unst", r0_unst, 32'h0);
        check("rst_valid", 32'(r0_valid), 32'd0);
        check("rst_busy", 32'(b0), 32'd0);
        check("rst_rdy", 32'(c0_ready), 32'd1);
        check("rst1_busy", 32'(b1), 32'd0);
        clear = 1'b0;

        // Stable PUF
        m0_base = 32'hA5A5_0F0F;
        run_txn(32'h1234_5678, 0, 1'b0);
        check("dir_resp", r0_resp, 32'hA5A5_0F0F);
        check("dir_unst", r0_unst, 32'h0);

        // Bit 0 flips on evaluations 2 and 4
        m0_base = 32'h0; m0_flip[1] = 32'h1; m0_flip[3] = 32'h1;
        run_txn(32'hCAFE_0001, 1, 1'b0);
        check("flip24_resp", r0_resp, 32'h0);
        check("flip24_unst", r0_unst, 32'h1);

        // Bit 0 flips on evaluations 1, 2 and 3
        clear_flips();
        m0_flip[0] = 32'h1; m0_flip[1] = 32'h1; m0_flip[2] = 32'h1;
        run_txn(32'hCAFE_0002, 0, 1'b0);
        check("flip123_resp", r0_resp, 32'h1);
        check("flip123_unst", r0_unst, 32'h1);

        // Randomised bases and sparse per-evaluation flips
        for (int t = 0; t < 6; t++) begin
            m0_base = $urandom;
            for (int k = 0; k < 5; k++) m0_flip[k] = $urandom & $urandom & $urandom;
            run_txn($urandom, $urandom_range(0, 3), 1'b0);
        end

        // Backpressure with a competing challenge offered during the stall
        clear_flips();
        m0_base = $urandom;
        run_txn(32'h0BAD_F00D, 20, 1'b1);

        // Abort during RUN of evaluation 3
        m0_base = 32'hFFFF_FFFF;
        @(negedge clk);
        c0_chal = 32'h5555_AAAA; c0_valid = 1'b1;
        st0 = ev0;
        @(negedge clk);
        c0_valid = 1'b0;
        for (int n = 0; n < 100 && !((ev0 - st0) == 2 && p0_clr === 1'b0); n++) @(negedge clk);
        check("abort_reach", 32'((ev0 - st0) == 2 && p0_clr === 1'b0), 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("abort_busy", 32'(b0), 32'd0);
        check("abort_clr", 32'(p0_clr), 32'd1);
        check("abort_valid", 32'(r0_valid), 32'd0);
        check("abort_rdy", 32'(c0_ready), 32'd1);
        m0_base = 32'h0F0F_3C3C;
        m0_flip[0] = 32'h0000_0101; m0_flip[4] = 32'h8000_0001;
        run_txn(32'h7777_0003, 0, 1'b0);

        // Back-to-back with chal_valid and resp_ready held high
        clear_flips();
        m0_base = $urandom;
        ca = 32'hAAAA_0001; cb = 32'hBBBB_0002;
        ref_vote(m0_base, 5, er, eu);
        @(negedge clk);
        c0_chal = ca; c0_valid = 1'b1; r0_ready = 1'b1;
        acc = cyc; st0 = ev0;
        @(negedge clk);
        c0_chal = cb;
        for (int n = 0; n < 200 && r0_valid !== 1'b1; n++) @(negedge clk);
        d = cyc;
        check("b2b_lat1", 32'(d - acc), 32'd31);
        check("b2b_resp1", r0_resp, er);
        m0_base = ~m0_base;
        ref_vote(m0_base, 5, er, eu);
        @(negedge clk);
        check("b2b_rdy", 32'(c0_ready), 32'd1);
        check("b2b_chal_old", p0_chal, ca);
        acc = cyc; st0 = ev0;
        @(negedge clk);
        c0_valid = 1'b0;
        check("b2b_chal_new", p0_chal, cb);
        check("b2b_accept_gap", 32'(cyc - d), 32'd2);
        check("b2b_rdy_low", 32'(c0_ready), 32'd0);
        for (int n = 0; n < 200 && r0_valid !== 1'b1; n++) @(negedge clk);
        check("b2b_lat2", 32'(cyc - acc), 32'd31);
        check("b2b_resp2", r0_resp, er);
        check("b2b_unst2", r0_unst, eu);
        @(negedge clk);
        r0_ready = 1'b0;
        check("b2b_idle", 32'(b0), 32'd0);

        // NEVAL=1, SETTLE=1 instance
        for (int t = 0; t < 3; t++) begin
            m1_base = $urandom;
            @(negedge clk);
            c1_chal = $urandom; c1_valid = 1'b1;
            acc = cyc;
            @(negedge clk);
            c1_valid = 1'b0;
            check("n1_clr_arm", 32'(p1_clr), 32'd1);
            @(negedge clk);
            check("n1_clr_run", 32'(p1_clr), 32'd0);
            @(negedge clk);
            check("n1_clr_smp", 32'(p1_clr), 32'd0);
            @(negedge clk);
            check("n1_valid", 32'(r1_valid), 32'd1);
            check("n1_lat", 32'(cyc - acc), 32'd4);
            check("n1_resp", r1_resp, m1_base);
            check("n1_unst", r1_unst, 32'h0);
            check("n1_clr_done", 32'(p1_clr), 32'd1);
            r1_ready = 1'b1;
            @(negedge clk);
            r1_ready = 1'b0;
            check("n1_rdy", 32'(c1_ready), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
